// File: rtl/popcnt_pkg.sv
// Shared constants and state encoding for the popcount datapath.
package popcnt_pkg;
  localparam int LEN      = 125;
  localparam int CW       = $clog2(LEN);
  localparam int MAXCHUNK = 32;
  localparam int AW       = $clog2(MAXCHUNK * LEN + 1);
  // chunk counter only has to reach MAXCHUNK-1 before it is cleared
  localparam int NW       = $clog2(MAXCHUNK);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;
endpackage

// File: rtl/popacc_thresh.sv
// Accumulates per-chunk popcounts of one neuron and binarizes the total
// against a threshold captured on the neuron's first beat.
module popacc_thresh
  import popcnt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_cnt,
  input  logic          in_last,
  input  logic [AW-1:0] in_thr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_bit,
  output logic          err_ovf
);

  state_t        state, state_d;
  logic [AW-1:0] acc, acc_d;
  logic [NW-1:0] chunk_n, chunk_d;
  logic [AW-1:0] thr_q, thr_d;

  logic          accept, forced, done, hit;
  logic [AW-1:0] base, total, thr;

  // Stall only while a finished result is waiting on downstream.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // From IDLE there is no partial sum and the threshold is the live input.
  assign base   = (state == ACCUM) ? acc   : '0;
  assign thr    = (state == ACCUM) ? thr_q : in_thr;
  assign total  = base + AW'(in_cnt);
  assign hit    = (total >= thr);
  // The MAXCHUNK-th beat closes the neuron even without in_last.
  assign forced = (chunk_n == NW'(MAXCHUNK - 1)) && !in_last;
  assign done   = accept && (in_last || forced);

  // Next-state and accumulator update.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    chunk_d = chunk_n;
    thr_d   = thr_q;
    if (accept) begin
      if (state == IDLE) thr_d = in_thr;
      if (done) begin
        state_d = IDLE;
        acc_d   = '0;
        chunk_d = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = total;
        chunk_d = chunk_n + 1'b1;
      end
    end
  end

  // Accumulator state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      chunk_n <= '0;
      thr_q   <= '0;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      chunk_n <= chunk_d;
      thr_q   <= thr_d;
    end
  end

  // Result register; a load wins over a drain in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_bit   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_ovf <= accept && forced;
      if (done) begin
        out_valid <= 1'b1;
        out_sum   <= total;
        out_bit   <= hit;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_popacc_thresh.sv
// Self-checking bench: table vectors plus hand-written corner sequences,
// results checked through an expected-result queue.
module tb_popacc_thresh;
  import popcnt_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [CW-1:0] in_cnt;
  logic [AW-1:0] in_thr;
  logic          out_valid, out_ready, out_bit, err_ovf;
  logic [AW-1:0] out_sum;

  popacc_thresh dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt),
    .in_last(in_last), .in_thr(in_thr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_bit(out_bit), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit last;
    int thr;
    int esum;
    bit ebit;
  } vec_t;

  typedef struct {
    int sum;
    bit b;
  } res_t;

  res_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   stalls = 0;
  int   ovf_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pop and compare whenever a result is handed to downstream.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_ovf) ovf_seen++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          res_t r;
          r = q.pop_front();
          chk("out_sum", int'(out_sum), r.sum);
          chk("out_bit", int'(out_bit), int'(r.b));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic beat(input int cnt, input bit last, input int thr,
                      input bit push, input int esum, input bit ebit);
    bit ok;
    int n;
    res_t r;
    in_valid = 1'b1;
    in_cnt   = CW'(cnt);
    in_last  = last;
    in_thr   = AW'(thr);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      if (ok && push) begin
        r.sum = esum;
        r.b   = ebit;
        q.push_back(r);
      end
      if (!ok) stalls++;
      @(posedge clk);
      n++;
    end
    if (!ok) chk("beat_accept_timeout", 0, 1);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    rst = 1'b1; in_valid = 1'b0; in_cnt = '0; in_last = 1'b0;
    in_thr = '0; out_ready = 1'b1;

    // cnt, last, thr, expected sum/bit on last beats
    tbl.push_back('{125, 1'b1, 100, 125, 1'b1});
    tbl.push_back('{ 10, 1'b0,  61,   0, 1'b0});
    tbl.push_back('{ 20, 1'b0,   0,   0, 1'b0});
    tbl.push_back('{ 30, 1'b1,   0,  60, 1'b0});
    tbl.push_back('{ 60, 1'b0, 100,   0, 1'b0});
    tbl.push_back('{ 40, 1'b1, 999, 100, 1'b1});
    tbl.push_back('{  0, 1'b1,   0,   0, 1'b1});
    tbl.push_back('{  0, 1'b1,   1,   0, 1'b0});
    tbl.push_back('{125, 1'b1, 126, 125, 1'b0});
    tbl.push_back('{127, 1'b1, 127, 127, 1'b1});
    tbl.push_back('{  1, 1'b1,   2,   1, 1'b0});
    tbl.push_back('{  2, 1'b1,   2,   2, 1'b1});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum",   int'(out_sum),   0);
    chk("rst_out_bit",   int'(out_bit),   0);
    chk("rst_err_ovf",   int'(err_ovf),   0);
    chk("rst_in_ready",  int'(in_ready),  1);
    @(posedge clk); #1;

    // Table runs back to back with out_ready high: no stalls allowed.
    stalls = 0;
    foreach (tbl[i]) begin
      v = tbl[i];
      beat(v.cnt, v.last, v.thr, v.last, v.esum, v.ebit);
    end
    idle_cycle();
    chk("b2b_stalls", stalls, 0);
    idle_cycle();

    // Latency: result visible the cycle after the last beat.
    beat(77, 1'b1, 50, 1'b1, 77, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_out_valid", int'(out_valid), 1);
    chk("lat_out_sum",   int'(out_sum),   77);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drained_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;

    // Backpressure: result held, next neuron stalls, then drain+accept.
    out_ready = 1'b0;
    beat(7, 1'b1, 3, 1'b1, 7, 1'b1);
    in_valid = 1'b1; in_cnt = CW'(9); in_last = 1'b1; in_thr = AW'(10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_sum",  int'(out_sum),  7);
      chk("bp_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    begin
      res_t r;
      r.sum = 9; r.b = 1'b0;
      q.push_back(r);
    end
    @(negedge clk);
    chk("bp_release_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_new_out_sum", int'(out_sum), 9);
    @(posedge clk); #1;
    idle_cycle();

    // Forced termination after MAXCHUNK beats without in_last.
    ovf_seen = 0;
    for (int k = 0; k < MAXCHUNK; k++)
      beat(125, 1'b0, 0, (k == MAXCHUNK - 1), 4000, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_pulse",     int'(err_ovf),   1);
    chk("ovf_out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ovf_pulse_end", int'(err_ovf), 0);
    @(posedge clk); #1;
    beat(3, 1'b1, 4, 1'b1, 3, 1'b0);
    idle_cycle();
    idle_cycle();
    chk("ovf_pulse_count", ovf_seen, 1);

    // Reset mid-accumulation discards the partial sum.
    beat(50, 1'b0, 1, 1'b0, 0, 1'b0);
    beat(60, 1'b0, 1, 1'b0, 0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", int'(out_valid), 0);
    chk("rst2_in_ready",  int'(in_ready),  1);
    @(posedge clk); #1;
    beat(5, 1'b1, 5, 1'b1, 5, 1'b1);
    idle_cycle();
    idle_cycle();

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
